// File: rtl/gpio_32_irq_ctrl.sv
// Per-bit GPIO interrupt detector: edge/level detection, sticky W1C status,
// and registered irq / lowest-pending-index outputs for the CPU.
module gpio_32_irq_ctrl #(
  parameter int NUM_GPIO = 32,
  parameter int ID_W     = 5
) (
  input  logic                PCLK,
  input  logic                PRESET,
  input  logic [NUM_GPIO-1:0] debounced_gpio_in,
  input  logic [NUM_GPIO-1:0] int_en,
  input  logic [NUM_GPIO-1:0] int_type,
  input  logic [NUM_GPIO-1:0] int_pol,
  input  logic [NUM_GPIO-1:0] int_both,
  input  logic                clr_valid,
  input  logic [NUM_GPIO-1:0] clr_mask,
  output logic [NUM_GPIO-1:0] irq_status,
  output logic                irq,
  output logic [ID_W-1:0]     irq_id,
  output logic                irq_id_valid
);

  logic [NUM_GPIO-1:0] r_prev_in;
  logic [NUM_GPIO-1:0] r_status;
  logic                r_irq;
  logic [ID_W-1:0]     r_irq_id;
  logic                r_irq_id_valid;

  logic [NUM_GPIO-1:0] w_rise;
  logic [NUM_GPIO-1:0] w_fall;
  logic [NUM_GPIO-1:0] w_edge_hit;
  logic [NUM_GPIO-1:0] w_lvl_hit;
  logic [NUM_GPIO-1:0] w_clr;
  logic [NUM_GPIO-1:0] w_edge_nxt;
  logic [NUM_GPIO-1:0] w_lvl_nxt;
  logic [NUM_GPIO-1:0] w_status_nxt;
  logic [ID_W-1:0]     w_low_id;

  assign w_rise     = debounced_gpio_in & ~r_prev_in;
  assign w_fall     = ~debounced_gpio_in & r_prev_in;
  assign w_edge_hit = (int_both & (w_rise | w_fall))
                    | (~int_both & ((int_pol & w_rise) | (~int_pol & w_fall)));
  assign w_lvl_hit  = (int_pol & debounced_gpio_in) | (~int_pol & ~debounced_gpio_in);

  // A new edge event outranks a clear landing on the same cycle.
  assign w_clr        = {NUM_GPIO{clr_valid}} & clr_mask;
  assign w_edge_nxt   = (int_en & w_edge_hit) | (r_status & ~w_clr);
  assign w_lvl_nxt    = int_en & w_lvl_hit;
  assign w_status_nxt = (int_type & w_lvl_nxt) | (~int_type & w_edge_nxt);

  // Scan downward so the lowest set index is the last one written.
  always_comb begin
    w_low_id = '0;
    for (int i = NUM_GPIO - 1; i >= 0; i--) begin
      if (r_status[i]) w_low_id = ID_W'(i);
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_prev_in      <= '0;
      r_status       <= '0;
      r_irq          <= 1'b0;
      r_irq_id       <= '0;
      r_irq_id_valid <= 1'b0;
    end else begin
      r_prev_in      <= debounced_gpio_in;
      r_status       <= w_status_nxt;
      r_irq          <= |r_status;
      r_irq_id       <= w_low_id;
      r_irq_id_valid <= |r_status;
    end
  end

  assign irq_status   = r_status;
  assign irq          = r_irq;
  assign irq_id       = r_irq_id;
  assign irq_id_valid = r_irq_id_valid;

endmodule

// File: tb/tb_gpio_32_irq_ctrl.sv
// Self-checking bench for gpio_32_irq_ctrl: vector table with hand-derived
// status values, irq/id expectations queued one cycle behind the status.
module tb_gpio_32_irq_ctrl;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [31:0] debounced_gpio_in;
  logic [31:0] int_en;
  logic [31:0] int_type;
  logic [31:0] int_pol;
  logic [31:0] int_both;
  logic        clr_valid;
  logic [31:0] clr_mask;
  logic [31:0] irq_status;
  logic        irq;
  logic [4:0]  irq_id;
  logic        irq_id_valid;

  gpio_32_irq_ctrl #(.NUM_GPIO(32), .ID_W(5)) dut (
    .PCLK              (PCLK),
    .PRESET            (PRESET),
    .debounced_gpio_in (debounced_gpio_in),
    .int_en            (int_en),
    .int_type          (int_type),
    .int_pol           (int_pol),
    .int_both          (int_both),
    .clr_valid         (clr_valid),
    .clr_mask          (clr_mask),
    .irq_status        (irq_status),
    .irq               (irq),
    .irq_id            (irq_id),
    .irq_id_valid      (irq_id_valid)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic        rst;
    logic [31:0] din;
    logic [31:0] en;
    logic [31:0] typ;
    logic [31:0] pol;
    logic [31:0] both;
    logic        clr;
    logic [31:0] mask;
    logic [31:0] exp_status;
  } vec_t;

  typedef struct {
    logic [31:0] status;
    logic        irq;
    logic [4:0]  id;
    logic        idv;
    int          idx;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_prev_status = '0;

  function automatic logic [4:0] lowest(input logic [31:0] s);
    for (int i = 0; i < 32; i++) if (s[i]) return 5'(i);
    return 5'd0;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got 0x%08h expected 0x%08h", nm, idx, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic [31:0] din, input logic [31:0] en,
                     input logic [31:0] typ, input logic [31:0] pol, input logic [31:0] both,
                     input logic clr, input logic [31:0] mask, input logic [31:0] exp_status);
    vec_t v;
    v.rst = rst; v.din = din; v.en = en; v.typ = typ; v.pol = pol; v.both = both;
    v.clr = clr; v.mask = mask; v.exp_status = exp_status;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    exp_t got;
    @(negedge PCLK);
    PRESET            = v.rst;
    debounced_gpio_in = v.din;
    int_en            = v.en;
    int_type          = v.typ;
    int_pol           = v.pol;
    int_both          = v.both;
    clr_valid         = v.clr;
    clr_mask          = v.mask;
    e.idx = idx;
    if (v.rst) begin
      e.status = '0; e.irq = 1'b0; e.id = '0; e.idv = 1'b0;
      model_prev_status = '0;
    end else begin
      e.status = v.exp_status;
      e.irq    = |model_prev_status;
      e.id     = lowest(model_prev_status);
      e.idv    = |model_prev_status;
      model_prev_status = v.exp_status;
    end
    sb.push_back(e);
    @(posedge PCLK);
    #1;
    got = sb.pop_front();
    chk("irq_status",   got.idx, irq_status,          got.status);
    chk("irq",          got.idx, {31'd0, irq},          {31'd0, got.irq});
    chk("irq_id",       got.idx, {27'd0, irq_id},       {27'd0, got.id});
    chk("irq_id_valid", got.idx, {31'd0, irq_id_valid}, {31'd0, got.idv});
  endtask

  localparam logic [31:0] Z = 32'h0;
  localparam logic [31:0] ALL = 32'hFFFF_FFFF;

  initial begin
    // Reset held for three cycles with clean inputs.
    PRESET = 1'b1; debounced_gpio_in = '0; int_en = '0; int_type = '0;
    int_pol = '0; int_both = '0; clr_valid = 1'b0; clr_mask = '0;
    for (int c = 0; c < 3; c++) begin
      @(posedge PCLK);
      #1;
      chk("rst_status", -1 - c, irq_status, Z);
      chk("rst_irq",    -1 - c, {31'd0, irq}, Z);
      chk("rst_idv",    -1 - c, {31'd0, irq_id_valid}, Z);
      chk("rst_id",     -1 - c, {27'd0, irq_id}, Z);
    end

    // Bit 3: rising edge, then W1C.
    add(0, Z,        32'h8, Z, 32'h8, Z, 0, Z,    Z);
    add(0, 32'h8,    32'h8, Z, 32'h8, Z, 0, Z,    32'h8);
    add(0, 32'h8,    32'h8, Z, 32'h8, Z, 0, Z,    32'h8);
    add(0, 32'h8,    32'h8, Z, 32'h8, Z, 1, 32'h8, Z);
    add(0, 32'h8,    32'h8, Z, 32'h8, Z, 0, Z,    Z);
    add(0, Z,        32'h8, Z, 32'h8, Z, 0, Z,    Z);
    // Bit 5: both edges; falling edge plus clear on the same cycle keeps the bit.
    add(0, 32'h20,   32'h20, Z, Z, 32'h20, 0, Z,      32'h20);
    add(0, 32'h20,   32'h20, Z, Z, 32'h20, 0, Z,      32'h20);
    add(0, Z,        32'h20, Z, Z, 32'h20, 1, 32'h20, 32'h20);
    add(0, Z,        32'h20, Z, Z, 32'h20, 1, 32'h20, Z);
    add(0, Z,        32'h20, Z, Z, 32'h20, 0, Z,      Z);
    // Bit 0: level active-low; clears cannot stick while the condition holds.
    add(0, Z,        32'h1, 32'h1, Z, Z, 0, Z,     32'h1);
    add(0, Z,        32'h1, 32'h1, Z, Z, 1, 32'h1, 32'h1);
    add(0, Z,        32'h1, 32'h1, Z, Z, 1, ALL,   32'h1);
    add(0, 32'h1,    32'h1, 32'h1, Z, Z, 0, Z,     Z);
    add(0, 32'h1,    32'h1, 32'h1, Z, Z, 0, Z,     Z);
    // Bits 7 and 20 together; lowest index reported first.
    add(0, 32'h0010_0080, 32'h0010_0080, Z, 32'h0010_0080, Z, 0, Z,             32'h0010_0080);
    add(0, 32'h0010_0080, 32'h0010_0080, Z, 32'h0010_0080, Z, 0, Z,             32'h0010_0080);
    add(0, 32'h0010_0080, 32'h0010_0080, Z, 32'h0010_0080, Z, 1, 32'h80,        32'h0010_0000);
    add(0, 32'h0010_0080, 32'h0010_0080, Z, 32'h0010_0080, Z, 0, Z,             32'h0010_0000);
    add(0, 32'h0010_0080, 32'h0010_0080, Z, 32'h0010_0080, Z, 1, 32'h0010_0000, Z);
    add(0, 32'h0010_0080, 32'h0010_0080, Z, 32'h0010_0080, Z, 0, Z,             Z);
    // Bit 9: latched, then disabled; retained, clearable, no re-set while disabled.
    add(0, 32'h0010_0280, 32'h200, Z, 32'h200, Z, 0, Z,      32'h200);
    add(0, 32'h0010_0280, Z,       Z, 32'h200, Z, 0, Z,      32'h200);
    add(0, 32'h0010_0280, Z,       Z, 32'h200, Z, 0, Z,      32'h200);
    add(0, 32'h0010_0280, Z,       Z, 32'h200, Z, 1, 32'h200, Z);
    add(0, 32'h0010_0080, Z,       Z, 32'h200, Z, 0, Z,      Z);
    add(0, 32'h0010_0280, Z,       Z, 32'h200, Z, 0, Z,      Z);
    add(0, 32'h0010_0280, Z,       Z, 32'h200, Z, 0, Z,      Z);
    // Mid-run reset; input already high counts as a rising edge afterwards.
    add(0, 32'h1, 32'h1, Z, 32'h1, Z, 0, Z, 32'h1);
    add(1, 32'h1, 32'h1, Z, 32'h1, Z, 0, Z, Z);
    add(0, 32'h1, 32'h1, Z, 32'h1, Z, 0, Z, 32'h1);
    add(0, 32'h1, 32'h1, Z, 32'h1, Z, 0, Z, 32'h1);
    // Polarity / both changes on a static input create no event.
    add(0, 32'h1, 32'h1, Z,     32'h1, Z,     1, 32'h1, Z);
    add(0, 32'h1, 32'h1, Z,     Z,     Z,     0, Z,     Z);
    add(0, 32'h1, 32'h1, Z,     Z,     32'h1, 0, Z,     Z);
    add(0, Z,     32'h1, Z,     Z,     32'h1, 0, Z,     32'h1);
    add(0, Z,     32'h1, 32'h1, 32'h1, Z,     0, Z,     Z);
    add(0, Z,     32'h1, 32'h1, Z,     Z,     0, Z,     32'h1);

    for (int k = 0; k < vecs.size(); k++) apply(vecs[k], k);

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_32_irq_ctrl.md
Name: gpio_32_irq_ctrl

Overview:
- Per-bit interrupt detector and status holder for the 32-bit GPIO bank.
- Sits directly downstream of the debounce stage and consumes its clean `debounced_gpio_in` vector.
- Detects per-bit edge or level events, latches them in a sticky status register with write-1-to-clear, and drives a single registered interrupt line plus the lowest pending bit index to the APB register block and CPU.

Parameters:
- NUM_GPIO, 32, number of GPIO bits handled (bank fixed at 32).
- ID_W, 5, width of the pending-index output (log2 of NUM_GPIO).

Ports:
- PCLK  in  1  single system clock; all state updates on rising edge.
- PRESET  in  1  reset, synchronous, active-high.
- debounced_gpio_in  in  32  clean input vector from the debounce stage.
- int_en  in  32  per-bit interrupt enable.
- int_type  in  32  per-bit mode: 1 = level, 0 = edge.
- int_pol  in  32  edge: 1 = rising, 0 = falling. Level: 1 = active-high, 0 = active-low.
- int_both  in  32  edge mode only: 1 = both edges (overrides int_pol).
- clr_valid  in  1  single-cycle write-1-to-clear strobe.
- clr_mask  in  32  bits to clear when clr_valid = 1.
- irq_status  out  32  latched status per bit.
- irq  out  1  registered OR of irq_status.
- irq_id  out  ID_W  index of lowest-numbered set status bit (registered).
- irq_id_valid  out  1  1 when any status bit is set (registered).

Behaviour:
- Reset (PRESET = 1 at a PCLK edge): prev_in = 0, irq_status = 0, irq = 0, irq_id = 0, irq_id_valid = 0. Reset wins over all other inputs on that edge.
- prev_in register: samples debounced_gpio_in on every non-reset edge.
- Per-bit edge detection (combinational, same cycle):
  - rise = in & ~prev_in.
  - fall = ~in & prev_in.
  - edge_hit = int_both ? (rise | fall) : (int_pol ? rise : fall).
- Level detection: lvl_hit = int_pol ? in : ~in.
- Edge mode (int_type = 0), per bit:
  - Status is sticky.
  - Next value = int_en & edge_hit ? 1 : (clr_valid & clr_mask ? 0 : hold).
  - A set on the same cycle as a clear wins; the bit stays 1.
- Level mode (int_type = 1), per bit:
  - Next value = int_en & lvl_hit.
  - The status bit tracks the condition with 1-cycle latency.
  - clr_valid has no lasting effect while the condition holds.
- int_en = 0:
  - No new sets.
  - Existing edge-mode status is retained and is still clearable.
  - Level-mode status drops on the next edge.
- Latency:
  - Input changes before edge k → irq_status set at edge k.
  - irq, irq_id and irq_id_valid are updated at edge k+1, computed from the irq_status value registered at edge k.
- irq_id priority: bit 0 is highest; irq_id = 0 when no bit is set.
- Config changes (int_type, int_pol, int_both) take effect on the next edge. Status bits are not cleared by a mode change.
- Changing int_pol on a static input creates no edge event, because detection uses prev_in vs. current input only.
- A first sample after reset with the input already at 1 counts as a rising edge (prev_in resets to 0).
- Simultaneous events on multiple bits are all latched in the same cycle. irq_id reports the lowest index.
- Reset asserted mid-operation: all state clears on that edge. The first post-reset edge is evaluated against prev_in = 0.

Test Plan:
- Reset with all inputs X-free, then run 3 cycles → irq_status = 0, irq = 0, irq_id_valid = 0 for every cycle PRESET was held.
- Bit 3: edge mode, rising, enabled. Input 0→1 before edge k → irq_status = 0x0000_0008 at edge k; irq = 1, irq_id = 3 at edge k+1. Then clr_valid with mask 0x8 → status 0; irq = 0 one cycle later.
- Bit 5: edge mode, both edges. Apply 1→0 and clear in the same cycle → status bit 5 stays 1 (set wins). A second clear with no edge → 0.
- Bit 0: level, active-low, enabled. Input held 0 → status bit 0 = 1; clr_valid pulses leave it at 1. Input → 1 → bit 0 = 0 the next edge.
- Bits 7 and 20 rise in the same cycle, both enabled → irq_status = 0x0010_0080; irq_id = 7. After clearing bit 7 → irq_id = 20, irq_id_valid = 1.
- Bit 9 latched (edge), then int_en[9] → 0 → status retained and irq still 1. A further rising edge on bit 9 does not re-set the bit once it has been cleared.
